// File: rtl/receiver_axis.sv
// -----------------------------------------------------------------------------
// receiver_axis
//   UART receiver for start + WORD_WIDTH data bits (LSB first) + one stop bit.
//   The serial line is brought into the clock domain by a two-flop
//   synchroniser. Every bit after the start bit is sampled near its centre.
//   Each good word is presented on an AXI4-Stream master port through a
//   one-word buffer.
//
// Ports
//   clk               system clock, rising edge
//   rst               synchronous reset, active-low
//   din               asynchronous serial input, idle high
//   dout_axis_tdata   received word
//   dout_axis_tvalid  tdata holds an unconsumed word
//   dout_axis_tready  consumer accepts the word
//   frame_error       one-cycle pulse, stop bit sampled low
//   overrun           one-cycle pulse, finished word dropped (buffer full)
//
// CLOCK_FREQUENCY / BAUD_RATE must be at least 4.
// -----------------------------------------------------------------------------
module receiver_axis #(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  output logic [WORD_WIDTH-1:0] dout_axis_tdata,
  output logic                  dout_axis_tvalid,
  input  logic                  dout_axis_tready,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam logic [31:0] CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam logic [31:0] HALF_BIT       = CLOCKS_PER_BIT / 32'd2;
  localparam logic [31:0] CPB_LAST       = CLOCKS_PER_BIT - 32'd1;
  localparam logic [31:0] HALF_LAST      = HALF_BIT - 32'd1;
  localparam logic [31:0] LAST_BIT       = WORD_WIDTH - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [31:0]           r_cnt;
  logic [31:0]           r_bit_idx;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  r_pend;
  logic [WORD_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_frame_error;
  logic                  r_overrun;

  logic                  w_rx;
  logic                  w_sample;
  logic                  w_stop_ok;
  logic                  w_stop_bad;
  logic                  w_counting;
  logic                  w_load;
  logic                  w_drop;

  assign w_rx = r_sync2;

  // Counting states restart their counter on a data-bit sample as well as on
  // any state change, so each data bit is measured from the previous sample.
  assign w_counting = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_STOP);

  // The buffer can take a word if it is empty or being drained this cycle.
  assign w_load = r_pend && (!r_tvalid || dout_axis_tready);
  assign w_drop = r_pend && r_tvalid && !dout_axis_tready;

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) w_state_nxt = S_START;
      end
      S_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (r_cnt == HALF_LAST) w_state_nxt = w_rx ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (r_cnt == CPB_LAST) begin
          w_sample = 1'b1;
          if (r_bit_idx == LAST_BIT) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == CPB_LAST) begin
          if (w_rx) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it cannot be mistaken for new frames.
        if (w_rx) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_pend        <= 1'b0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      // Synchroniser
      r_sync1 <= din;
      r_sync2 <= r_sync1;

      // Bit timing and deserialisation
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || w_sample || !w_counting) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end

      if (w_state_nxt != r_state) begin
        r_bit_idx <= '0;
      end else if (w_sample) begin
        r_bit_idx <= r_bit_idx + 32'd1;
      end

      // Right shift: the first bit received ends up in the LSB.
      if (w_sample) r_shift <= {w_rx, r_shift[WORD_WIDTH-1:1]};

      r_pend        <= w_stop_ok;
      r_frame_error <= w_stop_bad;

      // Output buffer
      r_overrun <= w_drop;
      if (w_load) begin
        r_tdata  <= r_shift;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && dout_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign dout_axis_tdata  = r_tdata;
  assign dout_axis_tvalid = r_tvalid;
  assign frame_error      = r_frame_error;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_receiver_axis.sv
module tb_receiver_axis;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       din;
  logic [7:0] dout_axis_tdata;
  logic       dout_axis_tvalid;
  logic       dout_axis_tready;
  logic       frame_error;
  logic       overrun;

  receiver_axis #(
    .CLOCK_FREQUENCY(32'd16),
    .BAUD_RATE      (32'd1),
    .WORD_WIDTH     (32'd8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .din             (din),
    .dout_axis_tdata (dout_axis_tdata),
    .dout_axis_tvalid(dout_axis_tvalid),
    .dout_axis_tready(dout_axis_tready),
    .frame_error     (frame_error),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec  = 0;
  int         n_fail = 0;
  int         fe_seen = 0;
  int         ov_seen = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  bit         lat_arm = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted word is popped and compared.
  always @(negedge clk) begin
    if (dout_axis_tvalid && dout_axis_tready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %02h, required no word", dout_axis_tdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout_axis_tdata !== e) begin
          n_fail++;
          $display("FAIL word: got %02h, required %02h", dout_axis_tdata, e);
        end
      end
    end
    if (lat_arm && dout_axis_tvalid) begin
      int lat;
      lat = cyc - start_cyc - 1;
      lat_arm = 1'b0;
      n_vec++;
      if (lat < 154 || lat > 155) begin
        n_fail++;
        $display("FAIL latency: got %0d cycles, required 154..155", lat);
      end
    end
    if (frame_error) fe_seen++;
    if (overrun) ov_seen++;
  end

  task automatic drive_bit(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      din = b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(stop, CPB);
  endtask

  task automatic send_word(input logic [7:0] d);
    exp_q.push_back(d);
    send_frame(d, 1'b1);
  endtask

  initial begin
    logic [7:0] part;
    rst = 1'b0;
    din = 1'b1;
    dout_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tvalid", {31'd0, dout_axis_tvalid}, 32'd0);
    check("reset_tdata", {24'd0, dout_axis_tdata}, 32'd0);
    check("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    drive_bit(1'b1, 10);

    // Single word with latency measurement
    start_cyc = cyc;
    lat_arm = 1'b1;
    send_word(8'hA5);
    drive_bit(1'b1, 20);
    check("latency_seen", {31'd0, lat_arm}, 32'd0);

    // Back-to-back frames, no idle gap
    send_word(8'h00);
    send_word(8'hFF);
    send_word(8'h5A);
    drive_bit(1'b1, 20);

    // Glitch shorter than half a bit, then a real frame
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 40);
    check("glitch_no_word", {31'd0, dout_axis_tvalid}, 32'd0);
    send_word(8'h3C);
    drive_bit(1'b1, 20);

    // Framing error followed by a held-low line
    send_frame(8'h81, 1'b0);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 20);
    check("frame_error_count", fe_seen, 32'd1);
    send_word(8'h42);
    drive_bit(1'b1, 20);

    // Back-pressure: second word is dropped
    dout_axis_tready = 1'b0;
    send_frame(8'h11, 1'b1);
    drive_bit(1'b1, 4);
    send_frame(8'h22, 1'b1);
    drive_bit(1'b1, 20);
    check("bp_overrun_count", ov_seen, 32'd1);
    check("bp_tvalid", {31'd0, dout_axis_tvalid}, 32'd1);
    check("bp_tdata", {24'd0, dout_axis_tdata}, 32'h11);
    exp_q.push_back(8'h11);
    dout_axis_tready = 1'b1;
    drive_bit(1'b1, 3);
    check("bp_drained_tvalid", {31'd0, dout_axis_tvalid}, 32'd0);

    // Reset in the middle of data bit 3 with a word in the buffer
    dout_axis_tready = 1'b0;
    send_frame(8'h77, 1'b1);
    drive_bit(1'b1, 20);
    check("pre_reset_tvalid", {31'd0, dout_axis_tvalid}, 32'd1);
    part = 8'h00;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(part[i], CPB);
    drive_bit(part[3], CPB / 2);
    rst = 1'b0;
    din = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    check("midreset_tvalid", {31'd0, dout_axis_tvalid}, 32'd0);
    check("midreset_tdata", {24'd0, dout_axis_tdata}, 32'd0);
    check("midreset_frame_error", {31'd0, frame_error}, 32'd0);
    check("midreset_overrun", {31'd0, overrun}, 32'd0);
    dout_axis_tready = 1'b1;
    drive_bit(1'b1, 30);
    send_word(8'hC3);
    drive_bit(1'b1, 30);

    check("words_outstanding", exp_q.size(), 32'd0);
    check("final_frame_errors", fe_seen, 32'd1);
    check("final_overruns", ov_seen, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
